// File: rtl/hs32_ldsb.sv
// Load scoreboard for the hs32 pipeline: tracks two in-order outstanding loads,
// drives the decode1 RAW stall packets and the load write-back port.
package hs32_ldsb_pkg;
    localparam int unsigned RD_W   = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 2;

    typedef struct packed {
        logic            vld;
        logic [RD_W-1:0] rd;
        logic            lsu;
    } hs32_stall;

    typedef struct packed {
        logic            used;
        logic            kill;
        logic [RD_W-1:0] rd;
    } ldsb_entry_t;
endpackage

module hs32_ldsb
    import hs32_ldsb_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush_i,
    input  logic              iss_vld_i,
    input  logic [RD_W-1:0]   iss_rd_i,
    output logic              iss_rdy_o,
    input  logic              rsp_vld_i,
    input  logic [DATA_W-1:0] rsp_data_i,
    output logic              wb_vld_o,
    output logic [RD_W-1:0]   wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output hs32_stall         l1_o,
    output hs32_stall         l2_o,
    output logic              err_o
);

    ldsb_entry_t      e0_q, e1_q, e0_d, e1_d, new_e;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_d;
    logic             retire;
    logic             accept;

    assign retire    = rsp_vld_i && (cnt_q != CNT_W'(0));
    assign iss_rdy_o = (cnt_q < CNT_W'(2)) || retire;
    assign accept    = iss_vld_i && iss_rdy_o && !flush_i;
    assign err_d     = rsp_vld_i && (cnt_q == CNT_W'(0));

    // Write-back is same-cycle with the response; killed loads are swallowed.
    assign wb_vld_o  = retire && !e0_q.kill;
    assign wb_rd_o   = wb_vld_o ? e0_q.rd : RD_W'(0);
    assign wb_data_o = wb_vld_o ? rsp_data_i : DATA_W'(0);

    // Stall packets come from registered state so a load stalls through its write-back cycle.
    assign l1_o = '{vld: e0_q.used && !e0_q.kill, rd: e0_q.rd, lsu: e0_q.used};
    assign l2_o = '{vld: e1_q.used && !e1_q.kill, rd: e1_q.rd, lsu: e1_q.used};

    // Next state: retire first, then flush the survivors, then place the new issue.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        new_e = '{used: 1'b1, kill: 1'b0, rd: iss_rd_i};
        if (retire) begin
            e0_d  = e1_q;
            e1_d  = '0;
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (flush_i) begin
            e0_d.kill = e0_d.kill || e0_d.used;
            e1_d.kill = e1_d.kill || e1_d.used;
        end
        if (accept) begin
            if (cnt_d == CNT_W'(0)) begin
                e0_d = new_e;
            end else begin
                e1_d = new_e;
            end
            cnt_d = cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
            err_o <= 1'b0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
            err_o <= err_d;
        end
    end

endmodule

// File: tb/tb_hs32_ldsb.sv
// Directed scoreboard bench for hs32_ldsb: a queue model of outstanding loads
// predicts write-back, stall packets, ready and error pulses.
module tb_hs32_ldsb;
    import hs32_ldsb_pkg::*;

    logic              clk = 1'b0;
    logic              rstn;
    logic              flush_i;
    logic              iss_vld_i;
    logic [3:0]        iss_rd_i;
    logic              iss_rdy_o;
    logic              rsp_vld_i;
    logic [31:0]       rsp_data_i;
    logic              wb_vld_o;
    logic [3:0]        wb_rd_o;
    logic [31:0]       wb_data_o;
    hs32_stall         l1_o;
    hs32_stall         l2_o;
    logic              err_o;

    typedef struct {
        logic [3:0] rd;
        bit         kill;
    } ld_t;

    ld_t q[$];
    bit  exp_err;
    int  errors = 0;
    int  checks = 0;

    always #5 clk = ~clk;

    hs32_ldsb dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush_i    (flush_i),
        .iss_vld_i  (iss_vld_i),
        .iss_rd_i   (iss_rd_i),
        .iss_rdy_o  (iss_rdy_o),
        .rsp_vld_i  (rsp_vld_i),
        .rsp_data_i (rsp_data_i),
        .wb_vld_o   (wb_vld_o),
        .wb_rd_o    (wb_rd_o),
        .wb_data_o  (wb_data_o),
        .l1_o       (l1_o),
        .l2_o       (l2_o),
        .err_o      (err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Registered-state checks against the model queue.
    task automatic chk_state(input string tag);
        chk({tag, ".l1.vld"}, 64'(l1_o.vld), 64'(q.size() > 0 && !q[0].kill));
        chk({tag, ".l1.lsu"}, 64'(l1_o.lsu), 64'(q.size() > 0));
        if (q.size() > 0) chk({tag, ".l1.rd"}, 64'(l1_o.rd), 64'(q[0].rd));
        chk({tag, ".l2.vld"}, 64'(l2_o.vld), 64'(q.size() > 1 && !q[1].kill));
        chk({tag, ".l2.lsu"}, 64'(l2_o.lsu), 64'(q.size() > 1));
        if (q.size() > 1) chk({tag, ".l2.rd"}, 64'(l2_o.rd), 64'(q[1].rd));
        chk({tag, ".err"}, 64'(err_o), 64'(exp_err));
    endtask

    // One clock: drive at posedge+1, check combinational outputs, advance model, check state.
    task automatic step(input string tag, input bit iv, input logic [3:0] ird,
                        input bit rv, input logic [31:0] rdat, input bit fl);
        ld_t hd;
        bit  rdy;
        bit  ret;
        iss_vld_i  = iv;
        iss_rd_i   = ird;
        rsp_vld_i  = rv;
        rsp_data_i = rdat;
        flush_i    = fl;
        #3;
        ret = rv && q.size() != 0;
        rdy = (q.size() < 2) || ret;
        chk({tag, ".rdy"}, 64'(iss_rdy_o), 64'(rdy));
        if (ret) begin
            hd = q.pop_front();
            chk({tag, ".wb_vld"}, 64'(wb_vld_o), 64'(!hd.kill));
            chk({tag, ".wb_rd"}, 64'(wb_rd_o), hd.kill ? 64'd0 : 64'(hd.rd));
            chk({tag, ".wb_data"}, 64'(wb_data_o), hd.kill ? 64'd0 : 64'(rdat));
        end else begin
            chk({tag, ".wb_vld"}, 64'(wb_vld_o), 64'd0);
        end
        if (fl) foreach (q[i]) q[i].kill = 1'b1;
        if (iv && rdy && !fl) q.push_back('{rd: ird, kill: 1'b0});
        exp_err = rv && !ret;
        @(posedge clk);
        #1;
        iss_vld_i = 1'b0; rsp_vld_i = 1'b0; flush_i = 1'b0;
        iss_rd_i = '0; rsp_data_i = '0;
        chk_state(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        rstn = 1'b0; flush_i = 1'b0; iss_vld_i = 1'b0; iss_rd_i = '0;
        rsp_vld_i = 1'b0; rsp_data_i = '0; exp_err = 1'b0;
        #12;
        chk("rst.l1", 64'(l1_o), 64'd0);
        chk("rst.l2", 64'(l2_o), 64'd0);
        chk("rst.rdy", 64'(iss_rdy_o), 64'd1);
        chk("rst.wb", {31'd0, wb_vld_o, wb_rd_o, wb_data_o}, 64'd0);
        chk("rst.err", 64'(err_o), 64'd0);
        @(posedge clk); #4; rstn = 1'b1;
        @(posedge clk); #1;

        // T1 single load and its write-back
        step("t1.iss", 1'b1, 4'd3, 1'b0, 32'd0, 1'b0);
        step("t1.rsp", 1'b0, 4'd0, 1'b1, 32'hDEADBEEF, 1'b0);

        // T2 full, then issue alongside retire
        step("t2.iss4", 1'b1, 4'd4, 1'b0, 32'd0, 1'b0);
        step("t2.iss7", 1'b1, 4'd7, 1'b0, 32'd0, 1'b0);
        step("t2.full", 1'b1, 4'd1, 1'b0, 32'd0, 1'b0);
        step("t2.rsp9", 1'b1, 4'd9, 1'b1, 32'h1111_2222, 1'b0);
        step("t2.rsp7", 1'b0, 4'd0, 1'b1, 32'h3333_4444, 1'b0);
        step("t2.rsp9b", 1'b0, 4'd0, 1'b1, 32'h5555_6666, 1'b0);

        // T3 flush with issue: both outstanding killed, issue dropped
        step("t3.iss5", 1'b1, 4'd5, 1'b0, 32'd0, 1'b0);
        step("t3.iss6", 1'b1, 4'd6, 1'b0, 32'd0, 1'b0);
        step("t3.fl", 1'b1, 4'd8, 1'b0, 32'd0, 1'b1);
        step("t3.rsp1", 1'b0, 4'd0, 1'b1, 32'hAAAA_0001, 1'b0);
        step("t3.rsp2", 1'b0, 4'd0, 1'b1, 32'hAAAA_0002, 1'b0);
        idle("t3.empty");

        // T4 flush in the response cycle of the older load
        step("t4.iss5", 1'b1, 4'd5, 1'b0, 32'd0, 1'b0);
        step("t4.iss6", 1'b1, 4'd6, 1'b0, 32'd0, 1'b0);
        step("t4.rspfl", 1'b0, 4'd0, 1'b1, 32'h0BAD_F00D, 1'b1);
        step("t4.rsp6", 1'b0, 4'd0, 1'b1, 32'h0000_0006, 1'b0);

        // New issue queues behind a killed entry; duplicate rd is legal
        step("q.iss5", 1'b1, 4'd5, 1'b0, 32'd0, 1'b0);
        step("q.fl", 1'b0, 4'd0, 1'b0, 32'd0, 1'b1);
        step("q.iss6", 1'b1, 4'd6, 1'b0, 32'd0, 1'b0);
        step("q.rsp5", 1'b0, 4'd0, 1'b1, 32'h5, 1'b0);
        step("q.dup", 1'b1, 4'd6, 1'b0, 32'd0, 1'b0);
        step("q.rsp6a", 1'b0, 4'd0, 1'b1, 32'h66, 1'b0);
        step("q.rsp6b", 1'b0, 4'd0, 1'b1, 32'h67, 1'b0);

        // T5 response with nothing outstanding
        step("t5.err", 1'b0, 4'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        idle("t5.once");
        step("t5.erriss", 1'b1, 4'd2, 1'b1, 32'h1234_5678, 1'b0);
        idle("t5.once2");
        step("t5.rsp2", 1'b0, 4'd0, 1'b1, 32'hCAFE_0002, 1'b0);

        // T6 asynchronous reset with two loads outstanding
        step("t6.iss1", 1'b1, 4'd10, 1'b0, 32'd0, 1'b0);
        step("t6.iss2", 1'b1, 4'd11, 1'b0, 32'd0, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6.l1", 64'(l1_o), 64'd0);
        chk("t6.l2", 64'(l2_o), 64'd0);
        chk("t6.rdy", 64'(iss_rdy_o), 64'd1);
        chk("t6.err", 64'(err_o), 64'd0);
        q.delete();
        exp_err = 1'b0;
        @(posedge clk); #4; rstn = 1'b1;
        @(posedge clk); #1;
        chk("t6.rdy2", 64'(iss_rdy_o), 64'd1);
        chk_state("t6.post");
        step("t6.lost", 1'b0, 4'd0, 1'b1, 32'hDEAD_0000, 1'b0);
        idle("t6.once");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
